led_mean_cal: RTL and testbench
===============================

// Module: led_mean_cal
// PURPOSE
//  Per-frame zone-mean statistics for the LED backlight path. Consumes a raster RGB888 pixel
//  stream, splits the frame into a 4x4 grid of equal zones, and outputs a 4-bit mean per
//  colour channel per zone. Sits between the video input and the LED zone driver.
//  start_o flags a fresh result set once per frame.
// PARAMETERS
//  ROW_LEN  1080  lines per frame; must be divisible by 4
//  COL_LEN  1920  pixels per line; must be divisible by 4
// PORTS
//  clk      in   1        single clock, all logic on rising edge
//  rst      in   1        synchronous, active-high reset
//  data_en  in   1        pixel valid; data sampled only when 1
//  data     in   24       pixel {R[23:16], G[15:8], B[7:0]}
//  MeanR    out  4 x [16] red zone means, unpacked [15:0]
//  MeanG    out  4 x [16] green zone means
//  MeanB    out  4 x [16] blue zone means
//  start_o  out  1        1-cycle pulse: new Mean* set valid
// BEHAVIOUR
//  - Reset: all Mean* = 0, start_o = 0, column/row counters = 0, partial accumulators cleared.
//  - Reset mid-frame discards the partial frame. The next accepted pixel is pixel (0,0).
//  - Raster order: left to right, top to bottom. Counters advance only on data_en=1.
//  - Gaps in data_en of any length are allowed and have no effect on results.
//  - Zone index z = (row/(ROW_LEN/4))*4 + (col/(COL_LEN/4)); zone 0 is top-left, zone 15 is
//    bottom-right.
//  - Accumulators: 48 unsigned sums (16 zones x 3 channels). Width is
//    ceil(log2(255*N+1)), N = ROW_LEN*COL_LEN/16. Default width is 25 bits. No overflow.
//  - Frame end: the pixel at (ROW_LEN-1, COL_LEN-1) is accepted. On that cycle, sums are
//    copied to a snapshot bank, the live accumulators are cleared, and counters wrap to (0,0).
//  - The next frame may start on the very next cycle without loss.
//  - Result: mean = min(15, floor(sum / (16*N))). This equals the upper nibble of the 8-bit
//    zone mean. Computed from the snapshot bank by a sequential divide/compare engine.
//  - All 48 results are written to Mean* together. start_o pulses high for exactly 1 cycle
//    with the new values already stable.
//  - Latency: start_o asserts at most 1024 cycles after the last pixel of the frame.
//  - Mean* hold their values until the next frame's update.
//  - If a new frame completes while the engine is busy, the new snapshot waits until the
//    engine is free; this cannot happen when the frame is larger than 1024 pixels.
//  - No output is produced for a partial frame.
// CONFIGURATION
//  MEAN_ROUND_EN defined: mean = min(15, floor((sum + 8*N) / (16*N))), i.e. round to nearest.
//  MEAN_ROUND_EN undefined (default): truncating floor as above.
// TESTING
//  1. Full frame, all pixels 0xFFFFFF -> one start_o pulse; all 48 means = 15.
//  2. Full frame, all pixels 0x000000 -> all means = 0; reset value also 0.
//  3. Zone z filled with R=0x80, G=0x40, B=0x10, all other zones 0 ->
//     MeanR[z]=8, MeanG[z]=4, MeanB[z]=1, all others 0.
//  4. Frame of 0x787878 with random ~50% data_en gaps -> all means = 7;
//     with MEAN_ROUND_EN -> all means = 8.
//  5. Two back-to-back frames with no idle cycles (0x202020 then 0xF0F0F0) ->
//     two start_o pulses; means 2 then 15.
//  6. rst asserted mid-frame, then one full 0x505050 frame -> exactly one start_o; means = 5.
//     Use ROW_LEN=8, COL_LEN=8 for quick runs.

Source files
------------

// File: rtl/led_mean_cal.sv
// Per-frame 4x4 zone-mean statistics (4-bit R/G/B means per zone) for the LED backlight path.
// Optional macro MEAN_ROUND_EN: round-to-nearest means instead of truncating floor.
module led_mean_cal #(
    parameter int ROW_LEN = 1080,
    parameter int COL_LEN = 1920
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_en,
    input  logic [23:0] data,
    output logic [3:0]  MeanR [15:0],
    output logic [3:0]  MeanG [15:0],
    output logic [3:0]  MeanB [15:0],
    output logic        start_o
);

    localparam int ZW    = COL_LEN / 4;
    localparam int ZH    = ROW_LEN / 4;
    localparam int N     = ZW * ZH;
    localparam int ACC_W = $clog2(255 * N + 1);
    localparam int DIV   = 16 * N;
`ifdef MEAN_ROUND_EN
    localparam int RND   = 8 * N;
`else
    localparam int RND   = 0;
`endif
    localparam int CW    = $clog2(ZW + 1);
    localparam int RW    = $clog2(ZH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_LOAD} state_t;

    logic [CW-1:0]    col_in;
    logic [1:0]       zc;
    logic [RW-1:0]    row_in;
    logic [1:0]       zr;
    logic [3:0]       zone;
    logic             frame_end;
    logic [ACC_W-1:0] pix_r, pix_g, pix_b;

    logic [ACC_W-1:0] acc_r_p0  [16];
    logic [ACC_W-1:0] acc_g_p0  [16];
    logic [ACC_W-1:0] acc_b_p0  [16];
    logic [ACC_W-1:0] snap_r_p1 [16];
    logic [ACC_W-1:0] snap_g_p1 [16];
    logic [ACC_W-1:0] snap_b_p1 [16];
    logic [3:0]       res_r_p2  [16];
    logic [3:0]       res_g_p2  [16];
    logic [3:0]       res_b_p2  [16];

    state_t           state;
    logic             pend_p1;
    logic [3:0]       idx;

    // Divide by 16*N via constant thresholds; the answer saturates at 15.
    function automatic logic [3:0] zone_mean(input logic [ACC_W-1:0] sum);
        logic [ACC_W:0] ext;
        logic [3:0]     q;
        ext = {1'b0, sum} + (ACC_W+1)'(RND);
        q   = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (ext >= (ACC_W+1)'(k * DIV)) q = 4'(k);
        end
        return q;
    endfunction

    assign zone      = {zr, zc};
    assign frame_end = data_en && (col_in == CW'(ZW - 1)) && (zc == 2'd3)
                       && (row_in == RW'(ZH - 1)) && (zr == 2'd3);
    assign pix_r     = ACC_W'(data[23:16]);
    assign pix_g     = ACC_W'(data[15:8]);
    assign pix_b     = ACC_W'(data[7:0]);

    // p0: raster position and live accumulation; p1: snapshot at frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            col_in <= '0;
            zc     <= '0;
            row_in <= '0;
            zr     <= '0;
            for (int z = 0; z < 16; z++) begin
                acc_r_p0[z]  <= '0;
                acc_g_p0[z]  <= '0;
                acc_b_p0[z]  <= '0;
                snap_r_p1[z] <= '0;
                snap_g_p1[z] <= '0;
                snap_b_p1[z] <= '0;
            end
        end else if (data_en) begin
            if (col_in == CW'(ZW - 1)) begin
                col_in <= '0;
                zc     <= zc + 2'd1;
                if (zc == 2'd3) begin
                    if (row_in == RW'(ZH - 1)) begin
                        row_in <= '0;
                        zr     <= zr + 2'd1;
                    end else begin
                        row_in <= row_in + RW'(1);
                    end
                end
            end else begin
                col_in <= col_in + CW'(1);
            end
            for (int z = 0; z < 16; z++) begin
                if (frame_end) begin
                    acc_r_p0[z]  <= '0;
                    acc_g_p0[z]  <= '0;
                    acc_b_p0[z]  <= '0;
                    snap_r_p1[z] <= acc_r_p0[z] + ((4'(z) == zone) ? pix_r : '0);
                    snap_g_p1[z] <= acc_g_p0[z] + ((4'(z) == zone) ? pix_g : '0);
                    snap_b_p1[z] <= acc_b_p0[z] + ((4'(z) == zone) ? pix_b : '0);
                end else if (4'(z) == zone) begin
                    acc_r_p0[z] <= acc_r_p0[z] + pix_r;
                    acc_g_p0[z] <= acc_g_p0[z] + pix_g;
                    acc_b_p0[z] <= acc_b_p0[z] + pix_b;
                end
            end
        end
    end

    // p2: one zone per cycle through the divide engine, then publish all 48 at once
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pend_p1 <= 1'b0;
            idx     <= '0;
            start_o <= 1'b0;
            for (int z = 0; z < 16; z++) begin
                res_r_p2[z] <= '0;
                res_g_p2[z] <= '0;
                res_b_p2[z] <= '0;
                MeanR[z]    <= '0;
                MeanG[z]    <= '0;
                MeanB[z]    <= '0;
            end
        end else begin
            start_o <= 1'b0;
            if (frame_end) pend_p1 <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (pend_p1) begin
                        state <= S_CALC;
                        idx   <= '0;
                        if (!frame_end) pend_p1 <= 1'b0;
                    end
                end
                S_CALC: begin
                    res_r_p2[idx] <= zone_mean(snap_r_p1[idx]);
                    res_g_p2[idx] <= zone_mean(snap_g_p1[idx]);
                    res_b_p2[idx] <= zone_mean(snap_b_p1[idx]);
                    idx           <= idx + 4'd1;
                    if (idx == 4'd15) state <= S_LOAD;
                end
                S_LOAD: begin
                    for (int z = 0; z < 16; z++) begin
                        MeanR[z] <= res_r_p2[z];
                        MeanG[z] <= res_g_p2[z];
                        MeanB[z] <= res_b_p2[z];
                    end
                    start_o <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_mean_cal.sv
// Scoreboard bench for led_mean_cal on an 8x8 frame (2x2-pixel zones).
module tb_led_mean_cal;

    localparam int ROW_LEN = 8;
    localparam int COL_LEN = 8;
    localparam int ZW = COL_LEN / 4;
    localparam int ZH = ROW_LEN / 4;
    localparam int N  = ZW * ZH;
`ifdef MEAN_ROUND_EN
    localparam int RND = 8 * N;
`else
    localparam int RND = 0;
`endif

    typedef struct {
        int r[16];
        int g[16];
        int b[16];
    } exp_t;

    logic        clk;
    logic        rst;
    logic        data_en;
    logic [23:0] data;
    logic [3:0]  MeanR [15:0];
    logic [3:0]  MeanG [15:0];
    logic [3:0]  MeanB [15:0];
    logic        start_o;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    int   n_start;
    int   n_push;
    logic start_prev;

    led_mean_cal #(.ROW_LEN(ROW_LEN), .COL_LEN(COL_LEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_en (data_en),
        .data    (data),
        .MeanR   (MeanR),
        .MeanG   (MeanG),
        .MeanB   (MeanB),
        .start_o (start_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int mean_of(input int sum);
        int m;
        m = (sum + RND) / (16 * N);
        return (m > 15) ? 15 : m;
    endfunction

    // mode 0: uniform px; mode 1: px only in zone zsel; mode 2: random pixels
    task automatic drive_frame(input int mode, input logic [23:0] px, input int zsel,
                               input int gap_pct);
        int sr[16], sg[16], sb[16];
        exp_t e;
        logic [23:0] p;
        int z;
        for (int i = 0; i < 16; i++) begin
            sr[i] = 0; sg[i] = 0; sb[i] = 0;
        end
        for (int row = 0; row < ROW_LEN; row++) begin
            for (int col = 0; col < COL_LEN; col++) begin
                z = (row / ZH) * 4 + (col / ZW);
                case (mode)
                    0:       p = px;
                    1:       p = (z == zsel) ? px : 24'h0;
                    default: p = 24'($urandom);
                endcase
                sr[z] += int'(p[23:16]);
                sg[z] += int'(p[15:8]);
                sb[z] += int'(p[7:0]);
                if (row == ROW_LEN - 1 && col == COL_LEN - 1) begin
                    for (int k = 0; k < 16; k++) begin
                        e.r[k] = mean_of(sr[k]);
                        e.g[k] = mean_of(sg[k]);
                        e.b[k] = mean_of(sb[k]);
                    end
                    exp_q.push_back(e);
                    n_push++;
                end
                while ($urandom_range(99) < gap_pct) begin
                    data_en = 1'b0;
                    data    = 24'($urandom);
                    @(posedge clk); #1;
                end
                data_en = 1'b1;
                data    = p;
                @(posedge clk); #1;
                data_en = 1'b0;
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int z = 0; z < 16; z++) begin
            check($sformatf("%s_R%0d", tag, z), int'(MeanR[z]), 0);
            check($sformatf("%s_G%0d", tag, z), int'(MeanG[z]), 0);
            check($sformatf("%s_B%0d", tag, z), int'(MeanB[z]), 0);
        end
        check({tag, "_start"}, int'(start_o), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (start_o) begin
            n_start++;
            check("start_len", int'(start_prev), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_start", 1, 0);
            end else begin
                e = exp_q.pop_front();
                for (int z = 0; z < 16; z++) begin
                    check($sformatf("MeanR%0d", z), int'(MeanR[z]), e.r[z]);
                    check($sformatf("MeanG%0d", z), int'(MeanG[z]), e.g[z]);
                    check($sformatf("MeanB%0d", z), int'(MeanB[z]), e.b[z]);
                end
            end
        end
        start_prev = start_o;
    end

    initial begin
        checks = 0; failures = 0; n_start = 0; n_push = 0; start_prev = 1'b0;
        rst = 1'b1; data_en = 1'b0; data = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        drive_frame(0, 24'hFFFFFF, 0, 0);
        wait_drain();
        drive_frame(0, 24'h000000, 0, 0);
        wait_drain();
        drive_frame(1, 24'h804010, 6, 0);
        wait_drain();
        drive_frame(1, 24'h804010, 15, 10);
        wait_drain();
        drive_frame(0, 24'h787878, 0, 50);
        wait_drain();
        drive_frame(2, 24'h0, 0, 20);
        wait_drain();
        // back-to-back, no idle cycles
        drive_frame(0, 24'h202020, 0, 0);
        drive_frame(0, 24'hF0F0F0, 0, 0);
        wait_drain();

        // partial frame discarded by a mid-frame reset
        for (int i = 0; i < 30; i++) begin
            data_en = 1'b1; data = 24'hFFFFFF;
            @(posedge clk); #1;
        end
        data_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("midreset");
        rst = 1'b0;
        drive_frame(0, 24'h505050, 0, 0);
        wait_drain();

        repeat (100) @(posedge clk);
        #1;
        check("pulses", n_start, n_push);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
